zigzag_reorder_buf: RTL

Double-buffered 8x8 coefficient reorder stage that sits directly downstream of the forward-DCT coefficient registers inside `fdct_zigzag`. It accepts 64 DCT coefficients per block in raster (row-major) order and re-emits them in JPEG zigzag order to the quantizer. Two 64-entry banks let one block be written while the previous one is read, so continuous streams run at one coefficient per clock.

---
 rtl/jpeg_zz_pkg.sv | 27 ++
 rtl/zz_bank_ram.sv | 34 +++
 rtl/zigzag_reorder_buf.sv | 119 +++++++++++
 3 files changed

// File: rtl/jpeg_zz_pkg.sv
// jpeg_zz_pkg
// Shared constants for the JPEG zigzag reorder path: block size, default
// coefficient width, the zigzag scan table and a lookup helper. The
// quantizer uses the same table to map a zigzag position k back to its
// raster address.
package jpeg_zz_pkg;

  localparam int BLK_SIZE = 64;
  localparam int COEF_W   = 12;

  // ZZ[k] = raster address (row*8 + col) of zigzag position k.
  localparam logic [5:0] ZZ [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz_addr(input logic [5:0] k);
    return ZZ[k];
  endfunction

endpackage

// File: rtl/zz_bank_ram.sv
// zz_bank_ram
// Two 64-entry coefficient banks held in flops. One synchronous write port,
// one combinational read port. Contents are never reset; validity is tracked
// by the owner through its bank-full flags.
//   clk       : clock
//   we_i      : write enable
//   wbank_i   : bank selected for write
//   waddr_i   : raster address written
//   wdata_i   : coefficient written
//   rbank_i   : bank selected for read
//   raddr_i   : address read
//   rdata_o   : coefficient at (rbank_i, raddr_i)
module zz_bank_ram #(
  parameter int COEF_W = 12
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [5:0]        waddr_i,
  input  logic [COEF_W-1:0] wdata_i,
  input  logic              rbank_i,
  input  logic [5:0]        raddr_i,
  output logic [COEF_W-1:0] rdata_o
);

  logic [COEF_W-1:0] mem_q [0:1][0:63];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wbank_i][waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[rbank_i][raddr_i];

endmodule

// File: rtl/zigzag_reorder_buf.sv
// zigzag_reorder_buf
// Double-buffered 8x8 reorder stage: coefficients arrive in raster order and
// leave in JPEG zigzag order, one per clock when both sides keep moving.
// One bank fills while the other drains through a single output register.
//   clk       : clock (rising edge)
//   rst       : synchronous active-high reset
//   in_valid  / in_ready  / in_coef   : raster-order input handshake
//   out_valid / out_ready / out_coef  : zigzag-order output handshake
//   out_idx   : zigzag position of out_coef
//   out_last  : out_idx is the final position of the block
module zigzag_reorder_buf #(
  parameter int COEF_W = jpeg_zz_pkg::COEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_coef,
  output logic [5:0]        out_idx,
  output logic              out_last
);
  import jpeg_zz_pkg::*;

  localparam logic [5:0] LAST = 6'(BLK_SIZE - 1);

  logic [1:0]        full_q, full_d;
  logic              wbank_q, wbank_d;
  logic [5:0]        wcnt_q, wcnt_d;
  logic              rbank_q, rbank_d;
  logic [5:0]        rcnt_q, rcnt_d;
  logic              out_valid_q, out_valid_d;
  logic [COEF_W-1:0] out_coef_q, out_coef_d;
  logic [5:0]        out_idx_q, out_idx_d;

  logic              wr_fire;
  logic              load;
  logic [COEF_W-1:0] rd_coef;

  zz_bank_ram #(.COEF_W(COEF_W)) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .wbank_i (wbank_q),
    .waddr_i (wcnt_q),
    .wdata_i (in_coef),
    .rbank_i (rbank_q),
    .raddr_i (zz_addr(rcnt_q)),
    .rdata_o (rd_coef)
  );

  assign in_ready = !full_q[wbank_q];
  assign wr_fire  = in_valid && in_ready;
  // The output register refills in the same cycle it hands a word downstream.
  assign load     = full_q[rbank_q] && (!out_valid_q || out_ready);

  always_comb begin
    full_d      = full_q;
    wbank_d     = wbank_q;
    wcnt_d      = wcnt_q;
    rbank_d     = rbank_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_coef_d  = out_coef_q;
    out_idx_d   = out_idx_q;

    if (wr_fire) begin
      wcnt_d = wcnt_q + 6'd1;
      if (wcnt_q == LAST) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = !wbank_q;
      end
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // Set above and clear here always target different banks, so both
    // updates to full_d survive.
    if (load) begin
      out_valid_d = 1'b1;
      out_coef_d  = rd_coef;
      out_idx_d   = rcnt_q;
      rcnt_d      = rcnt_q + 6'd1;
      if (rcnt_q == LAST) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = !rbank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 2'b00;
      wbank_q     <= 1'b0;
      wcnt_q      <= 6'd0;
      rbank_q     <= 1'b0;
      rcnt_q      <= 6'd0;
      out_valid_q <= 1'b0;
      out_coef_q  <= '0;
      out_idx_q   <= 6'd0;
    end else begin
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      rbank_q     <= rbank_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_coef_q  <= out_coef_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign out_idx   = out_idx_q;
  assign out_last  = (out_idx_q == LAST);

endmodule
